// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory-side arbiter: requester
// identity, ID-table entry layout and arbiter state encoding.
package wt_cache_pkg;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic       valid;
        arb_owner_e owner;
    } tid_entry_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wt_mem_req_arbiter_if.sv
// Request/return bundle between the two caches, the arbiter and the memory
// adapter; master is the arbiter's view, slave the surrounding logic's view.
interface wt_mem_req_arbiter_if #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned RtrnWidth = 128,
    parameter int unsigned TidWidth  = 2
);
    logic                 icache_req_i;
    logic                 icache_ack_o;
    logic [DataWidth-1:0] icache_data_i;
    logic [TidWidth-1:0]  icache_tid_i;
    logic                 dcache_req_i;
    logic                 dcache_ack_o;
    logic [DataWidth-1:0] dcache_data_i;
    logic [TidWidth-1:0]  dcache_tid_i;
    logic                 mem_req_o;
    logic                 mem_ack_i;
    logic [DataWidth-1:0] mem_data_o;
    logic [TidWidth-1:0]  mem_tid_o;
    logic                 mem_rtrn_vld_i;
    logic [TidWidth-1:0]  mem_rtrn_tid_i;
    logic [RtrnWidth-1:0] mem_rtrn_data_i;
    logic                 icache_rtrn_vld_o;
    logic                 dcache_rtrn_vld_o;
    logic [RtrnWidth-1:0] rtrn_data_o;

    modport master (
        input  icache_req_i, icache_data_i, icache_tid_i,
               dcache_req_i, dcache_data_i, dcache_tid_i,
               mem_ack_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        output icache_ack_o, dcache_ack_o, mem_req_o, mem_data_o, mem_tid_o,
               icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_data_o
    );

    modport slave (
        output icache_req_i, icache_data_i, icache_tid_i,
               dcache_req_i, dcache_data_i, dcache_tid_i,
               mem_ack_i, mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        input  icache_ack_o, dcache_ack_o, mem_req_o, mem_data_o, mem_tid_o,
               icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_data_o
    );

endinterface

// File: rtl/wt_mem_req_arbiter_tid_table.sv
// Transaction-ID ownership table: one entry per ID recording whether it is in
// flight and which cache issued it. Three combinational lookup ports.
module wt_tid_table
    import wt_cache_pkg::*;
#(
    parameter int unsigned TidWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_en,
    input  logic [TidWidth-1:0] alloc_tid,
    input  arb_owner_e          alloc_owner,
    input  logic                free_en,
    input  logic [TidWidth-1:0] free_tid,
    input  logic [TidWidth-1:0] req_i_tid,
    input  logic [TidWidth-1:0] req_d_tid,
    input  logic [TidWidth-1:0] rtrn_tid,
    output tid_entry_t          req_i_entry,
    output tid_entry_t          req_d_entry,
    output tid_entry_t          rtrn_entry
);
    localparam int unsigned Depth = 1 << TidWidth;

    tid_entry_t entries_q [Depth];

    // An ID being allocated can never be the one freed in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q <= '{default: '0};
        end else begin
            if (free_en) begin
                entries_q[free_tid].valid <= 1'b0;
            end
            if (alloc_en) begin
                entries_q[alloc_tid] <= '{valid: 1'b1, owner: alloc_owner};
            end
        end
    end

    assign req_i_entry = entries_q[req_i_tid];
    assign req_d_entry = entries_q[req_d_tid];
    assign rtrn_entry  = entries_q[rtrn_tid];

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the cache-to-memory request channel between I$
// and D$, with per-cache outstanding limits and ID-based return routing.
module wt_mem_req_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned DataWidth      = 128,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    wt_mem_req_arbiter_if.master bus,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int unsigned            CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0]    CntMax   = CntWidth'(MaxOutstanding);

    arb_state_e          state_q;
    arb_owner_e          owner_q;
    arb_owner_e          rr_prio_q;
    logic [CntWidth-1:0] cnt_i_q, cnt_d_q;

    tid_entry_t          req_i_entry, req_d_entry, rtrn_entry;
    logic                locked, elig_i, elig_d, pick_i;
    logic                alloc_en, rtrn_hit;
    logic                inc_i, inc_d, dec_i, dec_d;
    logic [DataWidth-1:0] sel_data;
    logic [TidWidth-1:0]  sel_tid;
    logic [RtrnWidth-1:0] rtrn_data;

    assign locked = (state_q == ARB_LOCKED);

    // Eligibility reads the registered table, so an ID freed this cycle is grantable next cycle.
    assign elig_i = bus.icache_req_i && !stall_i && (cnt_i_q < CntMax) && !req_i_entry.valid;
    assign elig_d = bus.dcache_req_i && !stall_i && (cnt_d_q < CntMax) && !req_d_entry.valid;
    assign pick_i = elig_i && (!elig_d || rr_prio_q == OWNER_ICACHE);

    always_comb begin
        sel_data = bus.icache_data_i;
        sel_tid  = bus.icache_tid_i;
        if (locked && owner_q == OWNER_DCACHE) begin
            sel_data = bus.dcache_data_i;
            sel_tid  = bus.dcache_tid_i;
        end
    end

    assign alloc_en = locked && bus.mem_ack_i;
    assign rtrn_hit = bus.mem_rtrn_vld_i && rtrn_entry.valid;
    assign inc_i    = alloc_en && owner_q == OWNER_ICACHE;
    assign inc_d    = alloc_en && owner_q == OWNER_DCACHE;
    assign dec_i    = rtrn_hit && rtrn_entry.owner == OWNER_ICACHE;
    assign dec_d    = rtrn_hit && rtrn_entry.owner == OWNER_DCACHE;

    wt_tid_table #(
        .TidWidth (TidWidth)
    ) u_tid_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_en    (alloc_en),
        .alloc_tid   (sel_tid),
        .alloc_owner (owner_q),
        .free_en     (rtrn_hit),
        .free_tid    (bus.mem_rtrn_tid_i),
        .req_i_tid   (bus.icache_tid_i),
        .req_d_tid   (bus.dcache_tid_i),
        .rtrn_tid    (bus.mem_rtrn_tid_i),
        .req_i_entry (req_i_entry),
        .req_d_entry (req_d_entry),
        .rtrn_entry  (rtrn_entry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_ICACHE;
            rr_prio_q <= OWNER_ICACHE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_i) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= OWNER_ICACHE;
                    end else if (elig_d) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= OWNER_DCACHE;
                    end
                end
                ARB_LOCKED: begin
                    if (bus.mem_ack_i) begin
                        state_q   <= ARB_IDLE;
                        rr_prio_q <= (owner_q == OWNER_ICACHE) ? OWNER_DCACHE : OWNER_ICACHE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_i_q <= '0;
            cnt_d_q <= '0;
        end else begin
            if (inc_i && !dec_i) begin
                cnt_i_q <= cnt_i_q + 1'b1;
            end else if (dec_i && !inc_i) begin
                cnt_i_q <= cnt_i_q - 1'b1;
            end
            if (inc_d && !dec_d) begin
                cnt_d_q <= cnt_d_q + 1'b1;
            end else if (dec_d && !inc_d) begin
                cnt_d_q <= cnt_d_q - 1'b1;
            end
        end
    end

    assign rtrn_data             = bus.mem_rtrn_data_i;
    assign bus.rtrn_data_o       = rtrn_data;
    assign bus.mem_req_o         = locked;
    assign bus.mem_data_o        = sel_data;
    assign bus.mem_tid_o         = sel_tid;
    assign bus.icache_ack_o      = inc_i;
    assign bus.dcache_ack_o      = inc_d;
    assign bus.icache_rtrn_vld_o = dec_i;
    assign bus.dcache_rtrn_vld_o = dec_d;
    assign err_o                 = bus.mem_rtrn_vld_i && !rtrn_entry.valid;
    assign busy_o                = locked || (cnt_i_q != '0) || (cnt_d_q != '0);

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level model.
module tb_wt_mem_req_arbiter;
    localparam int DW   = 128;
    localparam int RW   = 128;
    localparam int TW   = 2;
    localparam int MAXO = 2;
    localparam int NTID = 4;

    logic clk_i, rst_i, stall_i, busy_o, err_o;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 0;

    // Model: lock owner (-1 none, 0 I$, 1 D$), tie-break priority, owner per ID.
    int m_lock;
    int m_rr;
    int m_own [NTID];

    wt_mem_req_arbiter_if #(.DataWidth(DW), .RtrnWidth(RW), .TidWidth(TW)) bus ();

    wt_mem_req_arbiter #(
        .DataWidth      (DW),
        .RtrnWidth      (RW),
        .TidWidth       (TW),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int cnt_of(input int who);
        int c = 0;
        for (int t = 0; t < NTID; t++) if (m_own[t] == who) c++;
        return c;
    endfunction

    always @(negedge clk_i) begin
        int  e_own, lock_tid;
        bit  ei, ed;
        logic [DW-1:0] e_data;
        e_own = bus.mem_rtrn_vld_i ? m_own[bus.mem_rtrn_tid_i] : -1;
        if (chk_en) begin
            chk("mem_req", bus.mem_req_o, m_lock >= 0);
            chk("icache_ack", bus.icache_ack_o, m_lock == 0 && bus.mem_ack_i);
            chk("dcache_ack", bus.dcache_ack_o, m_lock == 1 && bus.mem_ack_i);
            if (m_lock >= 0) begin
                e_data = (m_lock == 1) ? bus.dcache_data_i : bus.icache_data_i;
                chk("mem_tid", bus.mem_tid_o, (m_lock == 1) ? bus.dcache_tid_i : bus.icache_tid_i);
                chk("mem_data", bus.mem_data_o, e_data);
            end
            chk("icache_rtrn_vld", bus.icache_rtrn_vld_o, bus.mem_rtrn_vld_i && e_own == 0);
            chk("dcache_rtrn_vld", bus.dcache_rtrn_vld_o, bus.mem_rtrn_vld_i && e_own == 1);
            chk("err", err_o, bus.mem_rtrn_vld_i && e_own < 0);
            chk("rtrn_data", bus.rtrn_data_o, bus.mem_rtrn_data_i);
            chk("busy", busy_o, m_lock >= 0 || cnt_of(0) > 0 || cnt_of(1) > 0);
        end
        if (rst_i) begin
            m_lock = -1;
            m_rr   = 0;
            for (int t = 0; t < NTID; t++) m_own[t] = -1;
        end else begin
            lock_tid = (m_lock == 1) ? int'(bus.dcache_tid_i) : int'(bus.icache_tid_i);
            if (m_lock < 0) begin
                ei = bus.icache_req_i && !stall_i && cnt_of(0) < MAXO && m_own[bus.icache_tid_i] < 0;
                ed = bus.dcache_req_i && !stall_i && cnt_of(1) < MAXO && m_own[bus.dcache_tid_i] < 0;
                if (ei && ed) m_lock = m_rr;
                else if (ei) m_lock = 0;
                else if (ed) m_lock = 1;
                if (e_own >= 0) m_own[bus.mem_rtrn_tid_i] = -1;
            end else begin
                if (e_own >= 0) m_own[bus.mem_rtrn_tid_i] = -1;
                if (bus.mem_ack_i) begin
                    m_own[lock_tid] = m_lock;
                    m_rr   = 1 - m_lock;
                    m_lock = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int who, input logic on, input int tid);
        if (who == 0) begin
            bus.icache_req_i  = on;
            bus.icache_tid_i  = TW'(tid);
            if (on) bus.icache_data_i = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            bus.dcache_req_i  = on;
            bus.dcache_tid_i  = TW'(tid);
            if (on) bus.dcache_data_i = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic issue(input int who, input int tid);
        logic seen;
        seen = 1'b0;
        set_req(who, 1'b1, tid);
        bus.mem_ack_i = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            #3;
            seen = (who == 0) ? bus.icache_ack_o : bus.dcache_ack_o;
            tick();
        end
        set_req(who, 1'b0, tid);
        bus.mem_ack_i = 1'b0;
        chk("issue_acked", seen, 1'b1);
    endtask

    task automatic rtrn(input logic vld, input int tid);
        bus.mem_rtrn_vld_i  = vld;
        bus.mem_rtrn_tid_i  = TW'(tid);
        bus.mem_rtrn_data_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int  got [4];
        int  n, pend, tid;
        logic i_ack, d_ack;
        clk_i = 0; rst_i = 1; stall_i = 0;
        bus.icache_req_i = 0; bus.icache_data_i = '0; bus.icache_tid_i = '0;
        bus.dcache_req_i = 0; bus.dcache_data_i = '0; bus.dcache_tid_i = '0;
        bus.mem_ack_i = 0; rtrn(1'b0, 0);
        tick(); tick();
        rst_i = 0; chk_en = 1;
        #3; chk("reset_mem_req", bus.mem_req_o, 1'b0); chk("reset_busy", busy_o, 1'b0);
        tick();

        // Single I$ request, tid 1
        bus.icache_req_i = 1; bus.icache_tid_i = 2'd1; bus.icache_data_i = {4{32'hA5A5_A5A5}};
        #3; chk("single_req_lat0", bus.mem_req_o, 1'b0);
        tick();
        #3; chk("single_req_lat1", bus.mem_req_o, 1'b1); chk("single_tid", bus.mem_tid_o, 2'd1);
        chk("single_data", bus.mem_data_o, {4{32'hA5A5_A5A5}});
        tick();
        bus.mem_ack_i = 1;
        #3; chk("single_ack", bus.icache_ack_o, 1'b1); chk("single_busy", busy_o, 1'b1);
        tick();
        bus.mem_ack_i = 0; bus.icache_req_i = 0; rtrn(1'b1, 1);
        #3; chk("single_rtrn_i", bus.icache_rtrn_vld_o, 1'b1); chk("single_rtrn_d", bus.dcache_rtrn_vld_o, 1'b0);
        tick();
        rtrn(1'b0, 0);
        #3; chk("single_idle_busy", busy_o, 1'b0);
        tick();

        // Return on an unallocated ID
        rtrn(1'b1, 2);
        #3; chk("err_pulse", err_o, 1'b1); chk("err_no_rtrn", bus.icache_rtrn_vld_o | bus.dcache_rtrn_vld_o, 1'b0);
        tick();
        rtrn(1'b0, 0);
        #3; chk("err_clear", err_o, 1'b0); chk("err_busy", busy_o, 1'b0);
        tick();

        // D$ outstanding limit
        issue(1, 0); issue(1, 1);
        set_req(1, 1'b1, 2); bus.mem_ack_i = 1;
        #3; chk("limit_block0", bus.mem_req_o, 1'b0); tick();
        #3; chk("limit_block1", bus.mem_req_o, 1'b0); tick();
        rtrn(1'b1, 0);
        #3; chk("limit_rtrn", bus.dcache_rtrn_vld_o, 1'b1); chk("limit_block2", bus.mem_req_o, 1'b0); tick();
        rtrn(1'b0, 0);
        #3; chk("limit_block3", bus.mem_req_o, 1'b0); tick();
        #3; chk("limit_grant", bus.mem_req_o, 1'b1); chk("limit_tid", bus.mem_tid_o, 2'd2);
        chk("limit_ack", bus.dcache_ack_o, 1'b1); tick();
        set_req(1, 1'b0, 2); bus.mem_ack_i = 0; rtrn(1'b1, 1); tick();
        rtrn(1'b1, 2); tick();
        rtrn(1'b0, 0);
        #3; chk("limit_drained", busy_o, 1'b0); tick();

        // Round robin with both held
        set_req(0, 1'b1, 0); set_req(1, 1'b1, 2); bus.mem_ack_i = 1;
        n = 0; pend = -1;
        for (int k = 0; k < 20 && n < 4; k++) begin
            rtrn(pend >= 0, (pend >= 0) ? pend : 0);
            pend = -1;
            #3;
            if (bus.icache_ack_o) begin got[n] = 0; n++; pend = 0; end
            else if (bus.dcache_ack_o) begin got[n] = 1; n++; pend = 2; end
            tick();
        end
        set_req(0, 1'b0, 0); set_req(1, 1'b0, 2); bus.mem_ack_i = 0;
        rtrn(pend >= 0, (pend >= 0) ? pend : 0);
        tick();
        rtrn(1'b0, 0);
        chk("rr_grants", n, 4);
        for (int i = 0; i < 4 && i < n; i++) chk("rr_order", got[i], i % 2);
        tick();

        // Reset while locked with one outstanding
        issue(0, 3);
        set_req(0, 1'b1, 1);
        tick();
        #3; chk("rst_locked", bus.mem_req_o, 1'b1); tick();
        rst_i = 1; stall_i = 1; tick();
        rst_i = 0;
        #3; chk("rst_mem_req", bus.mem_req_o, 1'b0); chk("rst_busy", busy_o, 1'b0); tick();
        set_req(0, 1'b0, 1); stall_i = 0; rtrn(1'b1, 3);
        #3; chk("rst_old_id_err", err_o, 1'b1); chk("rst_old_id_rtrn", bus.icache_rtrn_vld_o, 1'b0); tick();
        rtrn(1'b0, 0); tick();

        // Randomized traffic
        i_ack = 0; d_ack = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_i   = ($urandom_range(0, 599) == 0);
            stall_i = ($urandom_range(0, 7) == 0);
            bus.mem_ack_i = ($urandom_range(0, 2) != 0);
            if (i_ack) set_req(0, 1'b0, 0);
            else if (!bus.icache_req_i && $urandom_range(0, 3) == 0) set_req(0, 1'b1, $urandom_range(0, NTID - 1));
            if (d_ack) set_req(1, 1'b0, 0);
            else if (!bus.dcache_req_i && $urandom_range(0, 3) == 0) set_req(1, 1'b1, $urandom_range(0, NTID - 1));
            if ($urandom_range(0, 2) == 0) begin
                tid = $urandom_range(0, NTID - 1);
                if ($urandom_range(0, 5) != 0)
                    for (int t = 0; t < NTID; t++)
                        if (m_own[(tid + t) % NTID] >= 0) begin tid = (tid + t) % NTID; break; end
                rtrn(1'b1, tid);
            end else begin
                rtrn(1'b0, 0);
            end
            #3;
            i_ack = bus.icache_ack_o;
            d_ack = bus.dcache_ack_o;
            tick();
        end
        rst_i = 0; stall_i = 0; bus.mem_ack_i = 0;
        set_req(0, 1'b0, 0); set_req(1, 1'b0, 0); rtrn(1'b0, 0);
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
